// File: rtl/keyboard.sv
// keyboard: maps PS/2 key events onto an 8-voice note bank; define KEYBOARD_FREQ_CLEAR_EN to also zero a voice's frequency on release
module keyboard #(
  parameter logic [31:0] VOLUME_ON  = 32'h0010_0000,
  parameter int          NUM_VOICES = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [10:0]                      ps2_key,
  output logic [NUM_VOICES-1:0][15:0]      frequencies,
  output logic [NUM_VOICES-1:0][31:0]      voice_volumes
);
  logic                        toggle_q, toggle_d;
  logic [NUM_VOICES-1:0][15:0] freq_q, freq_d;
  logic [NUM_VOICES-1:0][31:0] vol_q, vol_d;
  logic                        hit;
  logic [2:0]                  idx;
  logic [15:0]                 note;
  logic                        key_event;
  // scancode to voice/frequency lookup; unmapped codes clear hit
  always_comb begin
    hit  = 1'b1;
    idx  = 3'd0;
    note = 16'd0;
    case (ps2_key[7:0])
      8'h15: begin idx = 3'd0; note = 16'd3520; end
      8'h1D: begin idx = 3'd1; note = 16'd3729; end
      8'h24: begin idx = 3'd2; note = 16'd3951; end
      8'h2D: begin idx = 3'd3; note = 16'd4186; end
      8'h2C: begin idx = 3'd4; note = 16'd4699; end
      8'h35: begin idx = 3'd5; note = 16'd4978; end
      8'h4A: begin idx = 3'd6; note = 16'd4400; end
      8'h49: begin idx = 3'd7; note = 16'd5274; end
      default: hit = 1'b0;
    endcase
  end
  assign key_event = ps2_key[10] != toggle_q;
  // next-state: a qualified event rewrites exactly one voice
  always_comb begin
    toggle_d = ps2_key[10];
    freq_d   = freq_q;
    vol_d    = vol_q;
    if (key_event && !ps2_key[8] && hit) begin
      vol_d[idx] = ps2_key[9] ? VOLUME_ON : 32'd0;
`ifdef KEYBOARD_FREQ_CLEAR_EN
      freq_d[idx] = ps2_key[9] ? note : 16'd0;
`else
      freq_d[idx] = ps2_key[9] ? note : freq_q[idx];
`endif
    end
  end
  // state registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      toggle_q <= 1'b0;
      freq_q   <= '0;
      vol_q    <= '0;
    end else begin
      toggle_q <= toggle_d;
      freq_q   <= freq_d;
      vol_q    <= vol_d;
    end
  end
  assign frequencies   = freq_q;
  assign voice_volumes = vol_q;
endmodule

// File: tb/tb_keyboard.sv
// tb_keyboard: randomized check of keyboard against a table-driven reference model
module tb_keyboard;
  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [10:0]           ps2_key = 11'h015;
  logic [7:0][15:0]      frequencies;
  logic [7:0][31:0]      voice_volumes;
  int                    checks = 0;
  int                    failures = 0;
  logic                  chk_en = 1'b0;
  logic [7:0]            codes [8] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h4A, 8'h49};
  logic [15:0]           ftab  [8] = '{16'd3520, 16'd3729, 16'd3951, 16'd4186, 16'd4699, 16'd4978, 16'd4400, 16'd5274};
  logic [15:0]           mf [8];
  logic [31:0]           mv [8];
  logic                  mprev;
  localparam logic [31:0] VOL = 32'd1048576;

  keyboard dut (.clk(clk), .reset(reset), .ps2_key(ps2_key), .frequencies(frequencies), .voice_volumes(voice_volumes));

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int v = 0; v < 8; v++) begin mf[v] = '0; mv[v] = '0; end
    mprev = 1'b0;
  endtask

  task automatic model_edge(input logic [10:0] k);
    logic ev;
    ev = k[10] != mprev;
    mprev = k[10];
    if (ev && !k[8])
      for (int v = 0; v < 8; v++)
        if (codes[v] == k[7:0]) begin
          if (k[9]) begin mf[v] = ftab[v]; mv[v] = VOL; end
          else begin
            mv[v] = '0;
`ifdef KEYBOARD_FREQ_CLEAR_EN
            mf[v] = '0;
`endif
          end
        end
  endtask

  task automatic step(input logic [10:0] k);
    @(negedge clk);
    ps2_key = k;
    @(posedge clk);
    model_edge(k);
    #1;
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // every-cycle comparison of all voices against the model
  always @(negedge clk) begin
    if (chk_en && !reset)
      for (int v = 0; v < 8; v++) begin
        checks++;
        if (frequencies[v] !== mf[v] || voice_volumes[v] !== mv[v]) begin
          failures++;
          $display("FAIL voice%0d @%0t: freq=%0d vol=%0d expected freq=%0d vol=%0d",
                   v, $time, frequencies[v], voice_volumes[v], mf[v], mv[v]);
        end
      end
  end

  initial begin
    logic [10:0] k;
    logic        tg;
    model_reset();
    repeat (3) @(negedge clk);
    lit("reset_freq0", {16'd0, frequencies[0]}, 32'd0);
    lit("reset_vol0", voice_volumes[0], 32'd0);
    reset = 1'b0;
    chk_en = 1'b1;
    step({1'b1, 1'b1, 1'b0, 8'h15});
    lit("press15_freq0", {16'd0, frequencies[0]}, 32'd3520);
    lit("press15_vol0", voice_volumes[0], 32'd1048576);
    lit("press15_vol1", voice_volumes[1], 32'd0);
    step({1'b1, 1'b1, 1'b0, 8'h15});
    lit("hold_vol0", voice_volumes[0], 32'd1048576);
    step({1'b0, 1'b1, 1'b0, 8'h4A});
    lit("press4a_freq6", {16'd0, frequencies[6]}, 32'd4400);
    lit("press4a_vol6", voice_volumes[6], 32'd1048576);
    lit("press4a_vol0", voice_volumes[0], 32'd1048576);
    step({1'b1, 1'b0, 1'b0, 8'h15});
    lit("rel15_vol0", voice_volumes[0], 32'd0);
`ifdef KEYBOARD_FREQ_CLEAR_EN
    lit("rel15_freq0", {16'd0, frequencies[0]}, 32'd0);
`else
    lit("rel15_freq0", {16'd0, frequencies[0]}, 32'd3520);
`endif
    lit("rel15_vol6", voice_volumes[6], 32'd1048576);
    step({1'b0, 1'b0, 1'b0, 8'h4A});
    lit("rel4a_vol6", voice_volumes[6], 32'd0);
`ifndef KEYBOARD_FREQ_CLEAR_EN
    lit("rel4a_freq6", {16'd0, frequencies[6]}, 32'd4400);
`endif
    step({1'b1, 1'b1, 1'b1, 8'h15});
    lit("ext_vol0", voice_volumes[0], 32'd0);
    step({1'b0, 1'b1, 1'b0, 8'h1C});
    step({1'b0, 1'b1, 1'b0, 8'h15});
    lit("stable_vol0", voice_volumes[0], 32'd0);
    step({1'b0, 1'b1, 1'b0, 8'h49});
    lit("stable_vol7", voice_volumes[7], 32'd0);
    tg = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      k[10]  = ($urandom_range(0, 1) == 1) ? ~tg : tg;
      tg     = k[10];
      k[9]   = $urandom_range(0, 1) == 1;
      k[8]   = $urandom_range(0, 7) == 0;
      k[7:0] = ($urandom_range(0, 9) < 8) ? codes[$urandom_range(0, 7)] : 8'($urandom);
      step(k);
    end
    step({~tg, 1'b1, 1'b0, 8'h15});
    step({tg, 1'b1, 1'b0, 8'h49});
    @(posedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    for (int v = 0; v < 8; v++) begin
      lit("async_freq", {16'd0, frequencies[v]}, 32'd0);
      lit("async_vol", voice_volumes[v], 32'd0);
    end
    ps2_key = {1'b1, 1'b1, 1'b0, 8'h2D};
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    model_edge(ps2_key);
    #1;
    lit("first_edge_vol3", voice_volumes[3], 32'd1048576);
    tg = 1'b1;
    for (int i = 0; i < 500; i++) begin
      k = 11'($urandom);
      if ($urandom_range(0, 3) != 0) k[7:0] = codes[$urandom_range(0, 7)];
      step(k);
    end
    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
